vlane_wb_stage: RTL and testbench

Writeback stage of the vector lane, directly downstream of the lane ALU. It takes one ALU result word per handshake and drives a single-entry registered write port into the lane's vector register file slice. It also packs the one-bit-per-element compare results into dense mask words before writing them. It tracks the word index within the current vector instruction, and it absorbs register-file backpressure.

---
 rtl/vlane_wb_pkg.sv | 22 ++
 rtl/vmask_packer.sv | 58 +++++
 rtl/vlane_wb_stage.sv | 109 ++++++++++
 tb/tb_vlane_wb_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vlane_wb_pkg.sv
// Shared types and helpers for the vector lane writeback stage.
// Element-width codes, FSM states and the mask packing ratio.
package vlane_wb_pkg;

    typedef enum logic [1:0] {
        Sew8  = 2'd0,
        Sew16 = 2'd1,
        Sew32 = 2'd2,
        Sew64 = 2'd3
    } sew_e;

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } wb_state_e;

    // Mask bits delivered per ALU beat: one per element of the given width.
    function automatic int unsigned elems_per_word(sew_e sew, int unsigned data_width);
        return data_width >> (32'd3 + 32'(sew));
    endfunction

endpackage

// File: rtl/vmask_packer.sv
// Packs per-beat compare bits into dense mask words for the writeback stage.
// Holds the partial word and fill pointer, and decides when a word is complete.
module vmask_packer
    import vlane_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  accept_i,
    input  logic [DATA_WIDTH-1:0] bits_i,
    input  sew_e                  sew_i,
    input  logic                  last_i,
    output logic                  flush_o,
    output logic [DATA_WIDTH-1:0] packed_o
);

    localparam int unsigned PtrW = $clog2(DATA_WIDTH) + 1;

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] low_mask, merged;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [PtrW-1:0]       n_elems, ptr_next;

    assign n_elems  = PtrW'(elems_per_word(sew_i, DATA_WIDTH));
    assign low_mask = (DATA_WIDTH'(1) << n_elems) - DATA_WIDTH'(1);
    // Bits above ptr+n are never set, so the merged word is already zero-filled.
    assign merged   = acc_q | ((bits_i & low_mask) << ptr_q);
    assign ptr_next = ptr_q + n_elems;

    assign flush_o  = accept_i && ((ptr_next == PtrW'(DATA_WIDTH)) || last_i);
    assign packed_o = merged;

    always_comb begin
        acc_d = acc_q;
        ptr_d = ptr_q;
        if (accept_i) begin
            if (flush_o) begin
                acc_d = '0;
                ptr_d = '0;
            end else begin
                acc_d = merged;
                ptr_d = ptr_next;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            ptr_q <= '0;
        end else begin
            acc_q <= acc_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vlane_wb_stage.sv
// Vector lane writeback stage: registered single-entry write port into the VRF slice.
// Tracks word index per instruction and packs compare results into mask words.
module vlane_wb_stage
    import vlane_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned WORD_IDX_BITS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_WIDTH-1:0]    in_result_i,
    input  logic                     in_mask_wb_i,
    input  logic [2:0]               in_sew_i,
    input  logic [REG_ADDR_BITS-1:0] in_dest_i,
    input  logic                     in_last_i,
    output logic                     wr_valid_o,
    input  logic                     wr_ready_i,
    output logic [REG_ADDR_BITS-1:0] wr_reg_o,
    output logic [WORD_IDX_BITS-1:0] wr_word_o,
    output logic [DATA_WIDTH-1:0]    wr_data_o,
    output logic                     busy_o
);

    logic                     accept, load, flush;
    logic [DATA_WIDTH-1:0]    packed_word;
    logic                     sew_unused;
    wb_state_e                state_q;

    logic                     wr_valid_q, wr_valid_d;
    logic [REG_ADDR_BITS-1:0] wr_reg_q, wr_reg_d;
    logic [WORD_IDX_BITS-1:0] wr_word_q, wr_word_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [WORD_IDX_BITS-1:0] word_cnt_q, word_cnt_d;

    assign sew_unused = in_sew_i[2];

    assign in_ready_o = !rst_i && (!wr_valid_q || wr_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    // Only normal beats and completed mask words occupy the write slot.
    assign load       = accept && (!in_mask_wb_i || flush);

    vmask_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .accept_i(accept && in_mask_wb_i),
        .bits_i  (in_result_i),
        .sew_i   (sew_e'(in_sew_i[1:0])),
        .last_i  (in_last_i),
        .flush_o (flush),
        .packed_o(packed_word)
    );

    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_reg_d   = wr_reg_q;
        wr_word_d  = wr_word_q;
        wr_data_d  = wr_data_q;
        word_cnt_d = word_cnt_q;
        if (load) begin
            wr_valid_d = 1'b1;
            wr_reg_d   = in_dest_i;
            wr_word_d  = word_cnt_q;
            wr_data_d  = in_mask_wb_i ? packed_word : in_result_i;
            word_cnt_d = in_last_i ? '0 : word_cnt_q + WORD_IDX_BITS'(1);
        end else if (wr_ready_i) begin
            wr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_valid_q <= 1'b0;
            wr_reg_q   <= '0;
            wr_word_q  <= '0;
            wr_data_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_reg_q   <= wr_reg_d;
            wr_word_q  <= wr_word_d;
            wr_data_q  <= wr_data_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle:   if (accept && !in_last_i) state_q <= StActive;
                StActive: if (accept && in_last_i) state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign wr_valid_o = wr_valid_q;
    assign wr_reg_o   = wr_reg_q;
    assign wr_word_o  = wr_word_q;
    assign wr_data_o  = wr_data_q;
    assign busy_o     = (state_q == StActive) || wr_valid_q;

endmodule

// File: tb/tb_vlane_wb_stage.sv
// Directed bench for vlane_wb_stage with a bit-queue reference model checked every cycle.
module tb_vlane_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] in_result_i = '0;
    logic        in_mask_wb_i = 1'b0;
    logic [2:0]  in_sew_i = '0;
    logic [4:0]  in_dest_i = '0;
    logic        in_last_i = 1'b0;
    logic        wr_valid_o;
    logic        wr_ready_i = 1'b1;
    logic [4:0]  wr_reg_o;
    logic [3:0]  wr_word_o;
    logic [63:0] wr_data_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    vlane_wb_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_result_i (in_result_i),
        .in_mask_wb_i(in_mask_wb_i),
        .in_sew_i    (in_sew_i),
        .in_dest_i   (in_dest_i),
        .in_last_i   (in_last_i),
        .wr_valid_o  (wr_valid_o),
        .wr_ready_i  (wr_ready_i),
        .wr_reg_o    (wr_reg_o),
        .wr_word_o   (wr_word_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: mask bits collected in a plain bit queue.
    bit          m_valid = 0;
    bit [4:0]    m_reg = 0;
    bit [3:0]    m_word = 0;
    bit [63:0]   m_data = 0;
    bit          m_active = 0;
    int          m_cnt = 0;
    bit          mbits[$];

    task automatic model_step();
        bit rdy;
        bit produce;
        bit [63:0] data;
        int n;
        if (rst_i) begin
            m_valid = 0; m_reg = 0; m_word = 0; m_data = 0;
            m_active = 0; m_cnt = 0; mbits.delete();
            return;
        end
        rdy = !m_valid || wr_ready_i;
        if (m_valid && wr_ready_i) m_valid = 0;
        if (in_valid_i && rdy) begin
            produce = 0;
            data = 0;
            if (!in_mask_wb_i) begin
                produce = 1;
                data = in_result_i;
            end else begin
                n = 64 / (8 << in_sew_i[1:0]);
                for (int i = 0; i < n; i++) mbits.push_back(in_result_i[i]);
                if (mbits.size() == 64 || in_last_i) begin
                    produce = 1;
                    for (int i = 0; i < mbits.size(); i++) data[i] = mbits[i];
                    mbits.delete();
                end
            end
            if (produce) begin
                m_valid = 1;
                m_reg = in_dest_i;
                m_word = 4'(m_cnt);
                m_data = data;
                m_cnt = in_last_i ? 0 : (m_cnt + 1) % 16;
            end
            m_active = !in_last_i;
        end
    endtask

    // DUT write log for the literal end-of-test checks.
    logic [72:0] wlog[$];

    always @(posedge clk_i) begin
        if (!rst_i && wr_valid_o && wr_ready_i) wlog.push_back({wr_reg_o, wr_word_o, wr_data_o});
        model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready_o), 64'(!rst_i && (!m_valid || wr_ready_i)));
            chk("wr_valid", 64'(wr_valid_o), 64'(m_valid));
            chk("busy", 64'(busy_o), 64'(m_active || m_valid));
            if (m_valid || rst_i) begin
                chk("wr_reg", 64'(wr_reg_o), 64'(m_reg));
                chk("wr_word", 64'(wr_word_o), 64'(m_word));
                chk("wr_data", wr_data_o, m_data);
            end
        end
    end

    task automatic beat(input logic [63:0] r, input logic m, input logic [2:0] s,
                        input logic [4:0] d, input logic l);
        int waited = 0;
        in_valid_i = 1; in_result_i = r; in_mask_wb_i = m;
        in_sew_i = s; in_dest_i = d; in_last_i = l;
        @(negedge clk_i);
        while (!in_ready_o && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        if (!in_ready_o) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_timeout: in_ready got 0 expected 1 within 50 cycles");
        end
        @(posedge clk_i); #1;
        in_valid_i = 0; in_last_i = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [72:0] exp);
        if (idx < wlog.size()) chk(name, wlog[idx][63:0], exp[63:0]);
        else chk(name, 64'hDEAD, exp[63:0]);
        if (idx < wlog.size()) chk({name, "_regword"}, 64'(wlog[idx][72:64]), 64'(exp[72:64]));
    endtask

    initial begin
        rst_i = 1;
        @(posedge clk_i); #1;
        chk_en = 1;
        @(negedge clk_i);
        chk("rst_in_ready", 64'(in_ready_o), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
        chk("rst_wr_data", wr_data_o, 64'd0);
        @(posedge clk_i); #1;
        rst_i = 0;
        idle(1);

        // Normal stream: three beats to v5.
        wlog.delete();
        beat(64'h1111_2222_3333_4444, 0, 3'd3, 5'd5, 0);
        beat(64'h5555_6666_7777_8888, 0, 3'd3, 5'd5, 0);
        beat(64'h9999_AAAA_BBBB_CCCC, 0, 3'd3, 5'd5, 1);
        idle(2);
        chk("norm_count", 64'(wlog.size()), 64'd3);
        chk_log("norm_w0", 0, {5'd5, 4'd0, 64'h1111_2222_3333_4444});
        chk_log("norm_w1", 1, {5'd5, 4'd1, 64'h5555_6666_7777_8888});
        chk_log("norm_w2", 2, {5'd5, 4'd2, 64'h9999_AAAA_BBBB_CCCC});
        chk("norm_busy_end", 64'(busy_o), 64'd0);

        // Mask pack at sew=0; upper junk bits must be ignored.
        wlog.delete();
        for (int k = 0; k < 8; k++) begin
            beat(64'hFFFF_0000_1234_5600 | 64'hA5, 1, 3'd0, 5'd7, k == 7);
            if (k < 7) chk("mask_early_write", 64'(wlog.size()), 64'd0);
        end
        idle(2);
        chk("mask_count", 64'(wlog.size()), 64'd1);
        chk_log("mask_word", 0, {5'd7, 4'd0, 64'hA5A5_A5A5_A5A5_A5A5});

        // Partial flush at sew=2.
        wlog.delete();
        beat(64'hFFFF_FFFF_FFFF_FFF1, 1, 3'd2, 5'd3, 0);
        beat(64'hFFFF_FFFF_FFFF_FFF2, 1, 3'd2, 5'd3, 0);
        beat(64'hFFFF_FFFF_FFFF_FFF3, 1, 3'd2, 5'd3, 1);
        idle(2);
        chk("part_count", 64'(wlog.size()), 64'd1);
        chk_log("part_word", 0, {5'd3, 4'd0, 64'h39});

        // Backpressure: first write stalls, second beat lands as it retires.
        wlog.delete();
        wr_ready_i = 0;
        beat(64'hCAFE_0000_0000_0001, 0, 3'd3, 5'd9, 0);
        in_valid_i = 1; in_result_i = 64'hCAFE_0000_0000_0002; in_last_i = 1;
        repeat (4) begin
            @(negedge clk_i);
            chk("bp_in_ready", 64'(in_ready_o), 64'd0);
            chk("bp_data_hold", wr_data_o, 64'hCAFE_0000_0000_0001);
            chk("bp_word_hold", 64'(wr_word_o), 64'd0);
            @(posedge clk_i); #1;
        end
        wr_ready_i = 1;
        @(negedge clk_i);
        chk("bp_release_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i); #1;
        in_valid_i = 0; in_last_i = 0;
        @(negedge clk_i);
        chk("bp_next_data", wr_data_o, 64'hCAFE_0000_0000_0002);
        chk("bp_next_word", 64'(wr_word_o), 64'd1);
        idle(2);
        chk("bp_count", 64'(wlog.size()), 64'd2);

        // Reset in the middle of a mask instruction.
        for (int k = 0; k < 4; k++) beat(64'hFF, 1, 3'd0, 5'd11, 0);
        rst_i = 1;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        chk("mrst_busy", 64'(busy_o), 64'd0);
        chk("mrst_wr_valid", 64'(wr_valid_o), 64'd0);
        chk("mrst_wr_data", wr_data_o, 64'd0);
        rst_i = 0;
        idle(1);
        wlog.delete();
        for (int k = 0; k < 8; k++) beat(64'h01, 1, 3'd0, 5'd12, k == 7);
        idle(2);
        chk("mrst_count", 64'(wlog.size()), 64'd1);
        chk_log("mrst_word", 0, {5'd12, 4'd0, 64'h0101_0101_0101_0101});

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
